inequality_sweep: RTL and testbench

- Sequential stimulus-and-check stage that sits directly upstream of the 4-bit combinational inequality block. It also consumes that block's 3-bit result.
- Drives NUM through all 16 codes, 0..15, in order. For each code it waits a settle window, samples OUT and compares it against a parameterised expected table.
- Reports the error count and the first failing vector.
- Gives on-chip self-test and replaces hand-written per-vector benches.

---
 rtl/inequality_pkg.sv | 40 ++++
 rtl/sweep_settle_counter.sv | 35 +++
 rtl/inequality_sweep.sv | 123 ++++++++++++
 tb/tb_inequality_sweep.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inequality_pkg.sv
// ============================================================================
// Module      : inequality_pkg
// Description : Shared state encoding, default widths and golden expected
//               table for the inequality sweep self-test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inequality_pkg;

  localparam int NUM_W_DEF = 4;
  localparam int OUT_W_DEF = 3;
  localparam int CODES_DEF = 1 << NUM_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Result of the inequality block: {num < 5, 5 <= num <= 10, num > 10}.
  function automatic logic [OUT_W_DEF-1:0] golden_out(input int k);
    return {k < 5, (k >= 5) && (k <= 10), k > 10};
  endfunction

  function automatic logic [OUT_W_DEF*CODES_DEF-1:0] build_golden();
    logic [OUT_W_DEF*CODES_DEF-1:0] t;
    t = '0;
    for (int k = 0; k < CODES_DEF; k++) begin
      t[OUT_W_DEF*k +: OUT_W_DEF] = golden_out(k);
    end
    return t;
  endfunction

  localparam logic [OUT_W_DEF*CODES_DEF-1:0] GOLDEN_EXP_TABLE = build_golden();

endpackage

`default_nettype wire

// File: rtl/sweep_settle_counter.sv
// ============================================================================
// Module      : sweep_settle_counter
// Description : Loadable down-counter with zero flag timing the settle window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_settle_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] value;

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

`default_nettype wire

// File: rtl/inequality_sweep.sv
// ============================================================================
// Module      : inequality_sweep
// Description : Sweeps NUM over every code, checks OUT against EXP_TABLE and
//               reports error count plus the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inequality_sweep
  import inequality_pkg::*;
#(
  parameter int NUM_W  = NUM_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SETTLE = 2,
  parameter logic [OUT_W*(2**NUM_W)-1:0] EXP_TABLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [NUM_W-1:0] NUM,
  input  logic [OUT_W-1:0] OUT,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NUM_W:0]   err_count,
  output logic             fail_valid,
  output logic [NUM_W-1:0] fail_num,
  output logic [OUT_W-1:0] fail_out
);

  localparam int                CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [NUM_W-1:0]  LAST_NUM    = '1;

  generate
    if (SETTLE < 1) begin : g_settle_check
      $error("inequality_sweep: SETTLE must be at least 1");
    end
  endgenerate

  state_t           state;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             starting;
  logic [OUT_W-1:0] exp_out;
  logic             mismatch;

  assign starting = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign cnt_load = starting || ((state == ST_SAMPLE) && (NUM != LAST_NUM));
  assign cnt_dec  = (state == ST_DRIVE);
  assign exp_out  = EXP_TABLE[OUT_W*int'(NUM) +: OUT_W];
  assign mismatch = (exp_out != OUT);

  sweep_settle_counter #(
    .CNT_W (CNT_W)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      NUM        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_num   <= '0;
      fail_out   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_DRIVE;
            NUM        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_num   <= '0;
            fail_out   <= '0;
          end
        end
        ST_DRIVE: begin
          if (cnt_zero) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // Only the first mismatch is latched; later ones just count.
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_num   <= NUM;
              fail_out   <= OUT;
            end
          end
          if (NUM == LAST_NUM) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            NUM   <= NUM + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pass = done && (err_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_inequality_sweep.sv
// ============================================================================
// Module      : tb_inequality_sweep
// Description : Self-checking bench for inequality_sweep with a cycle-level
//               reference model and fault-injecting inequality block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inequality_sweep;
  import inequality_pkg::*;

  localparam int NUM_W  = 4;
  localparam int OUT_W  = 3;
  localparam int SETTLE = 2;
  localparam int CODES  = 16;
  localparam int PER    = SETTLE + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NUM_W-1:0] num;
  logic [OUT_W-1:0] out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [NUM_W:0]   err_count;
  logic             fail_valid;
  logic [NUM_W-1:0] fail_num;
  logic [OUT_W-1:0] fail_out;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  inequality_sweep #(
    .NUM_W     (NUM_W),
    .OUT_W     (OUT_W),
    .SETTLE    (SETTLE),
    .EXP_TABLE (GOLDEN_EXP_TABLE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .NUM        (num),
    .OUT        (out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_num   (fail_num),
    .fail_out   (fail_out)
  );

  function automatic logic [2:0] ref_ineq(input int k);
    logic [2:0] r;
    r = 3'b000;
    if (k < 5)                 r = 3'b100;
    else if (k <= 10)          r = 3'b010;
    else                       r = 3'b001;
    return r;
  endfunction

  // Mode 1: bit0 stuck at 1 on codes 3 and 9. Mode 2: every output inverted.
  function automatic logic [2:0] block_out(input int k, input int m);
    logic [2:0] g;
    g = ref_ineq(k);
    if (m == 1 && (k == 3 || k == 9)) g[0] = 1'b1;
    if (m == 2) g = ~g;
    return g;
  endfunction

  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_fv     = 1'b0;
  int         m_phase  = 0;
  logic [3:0] m_num    = '0;
  logic [3:0] m_fn     = '0;
  logic [4:0] m_err    = '0;
  logic [2:0] m_fo     = '0;
  logic [2:0] glitch   = '0;

  // Mode 3 drives garbage on OUT except on the sampling cycle.
  always_comb begin
    out = block_out(int'(num), mode);
    if (mode == 3 && !(m_active && (m_phase % PER == PER - 1))) out = glitch;
  end

  always @(posedge clk) begin : model
    bit a, d, fv;
    int ph, k;
    logic [3:0] n, fn;
    logic [4:0] e;
    logic [2:0] fo, o;
    a = m_active; d = m_done; fv = m_fv; ph = m_phase;
    n = m_num; fn = m_fn; e = m_err; fo = m_fo;
    if (reset) begin
      a = 0; d = 0; fv = 0; ph = 0; n = 0; fn = 0; e = 0; fo = 0;
    end else if (!a && start) begin
      a = 1; d = 0; fv = 0; ph = 0; n = 0; fn = 0; e = 0; fo = 0;
    end else if (a) begin
      if (ph % PER == PER - 1) begin
        k = ph / PER;
        o = block_out(k, mode);
        if (o != ref_ineq(k)) begin
          e = e + 1;
          if (!fv) begin fv = 1; fn = 4'(k); fo = o; end
        end
      end
      ph = ph + 1;
      if (ph == CODES * PER) begin
        a = 0; d = 1; n = 4'(CODES - 1);
      end else begin
        n = 4'(ph / PER);
      end
    end
    m_active <= a; m_done <= d; m_fv <= fv; m_phase <= ph;
    m_num <= n; m_fn <= fn; m_err <= e; m_fo <= fo;
    glitch <= 3'($urandom_range(7, 0));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("NUM", 32'(num), 32'(m_num));
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_done && m_err == 0));
      check("err_count", 32'(err_count), 32'(m_err));
      check("fail_valid", 32'(fail_valid), 32'(m_fv));
      check("fail_num", 32'(fail_num), 32'(m_fn));
      check("fail_out", 32'(fail_out), 32'(m_fo));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_done(input bit pulses, input bit hold_end, output int cycles);
    cycles = 0;
    while (!done && cycles < 200) begin
      if (pulses) start = (cycles == 9) || (cycles == 19);
      if (hold_end && cycles >= 40) start = 1'b1;
      tick();
      cycles++;
    end
    if (cycles >= 200) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_sweep(input int m, input bit pulses, input bit hold_end, output int cycles);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(pulses, hold_end, cycles);
    if (!hold_end) start = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (3) tick();
    check("idle_num", 32'(num), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_err", 32'(err_count), 32'd0);
    check("idle_fail_valid", 32'(fail_valid), 32'd0);

    // Clean sweep with stray start pulses while busy.
    run_sweep(0, 1'b1, 1'b0, cyc);
    check("clean_latency", 32'(cyc), 32'd48);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_count), 32'd0);
    check("clean_num_held", 32'(num), 32'd15);
    repeat (4) tick();
    check("done_held", 32'(done), 32'd1);

    run_sweep(1, 1'b0, 1'b0, cyc);
    check("stuck_latency", 32'(cyc), 32'd48);
    check("stuck_pass", 32'(pass), 32'd0);
    check("stuck_err", 32'(err_count), 32'd2);
    check("stuck_fail_valid", 32'(fail_valid), 32'd1);
    check("stuck_fail_num", 32'(fail_num), 32'd3);
    check("stuck_fail_out", 32'(fail_out), 32'd5);

    run_sweep(2, 1'b0, 1'b0, cyc);
    check("allwrong_err", 32'(err_count), 32'd16);
    check("allwrong_fail_num", 32'(fail_num), 32'd0);
    check("allwrong_fail_out", 32'(fail_out), 32'd3);

    run_sweep(3, 1'b0, 1'b0, cyc);
    check("glitch_pass", 32'(pass), 32'd1);
    check("glitch_err", 32'(err_count), 32'd0);

    // Abort mid-sweep with errors already counted.
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (num != 4'd7 && n < 100) begin tick(); n++; end
    check("reach_num7", 32'(num), 32'd7);
    check("err_before_reset", 32'(err_count), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_num", 32'(num), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err_count), 32'd0);
    check("abort_fail_valid", 32'(fail_valid), 32'd0);
    run_sweep(0, 1'b0, 1'b0, cyc);
    check("after_abort_latency", 32'(cyc), 32'd48);
    check("after_abort_pass", 32'(pass), 32'd1);

    // start held high into DONE restarts immediately.
    run_sweep(0, 1'b0, 1'b1, cyc);
    check("hold_latency", 32'(cyc), 32'd48);
    check("hold_done_seen", 32'(done), 32'd1);
    tick();
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_num", 32'(num), 32'd0);
    wait_done(1'b0, 1'b0, cyc);
    check("restart_latency", 32'(cyc), 32'd48);
    check("restart_pass", 32'(pass), 32'd1);

    repeat (2) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
